mem_read_rr_arbiter: RTL

- Round-robin arbiter sharing one memory read port among N_REQ requesters, e.g. the engine's instruction fetch and the cache controller.
- Replaces fixed-priority memory arbitration in the coprocessor topology so no requester can starve.
- Locks the grant until the memory accepts, so the forwarded address stays stable.
- Keeps per-requester grant and wait statistics for the performance counters.

---
 rtl/mem_read_rr_arbiter_if.sv | 27 ++
 rtl/mem_read_rr_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_rr_arbiter_if.sv
// Shared read-port bundle between the requesters, the arbiter and the memory.
// The arbiter uses the master view; the environment driving requests and
// answering as memory uses the slave view.
interface mem_read_rr_arbiter_if #(
    parameter int N_REQ             = 2,
    parameter int MEMORY_ADDR_WIDTH = 11,
    parameter int MEMORY_WIDTH      = 16
);
    logic [N_REQ-1:0]                   req_valid;
    logic [N_REQ*MEMORY_ADDR_WIDTH-1:0] req_addr;
    logic [N_REQ-1:0]                   req_ready;
    logic [MEMORY_WIDTH-1:0]            req_data;
    logic                               mem_valid;
    logic [MEMORY_ADDR_WIDTH-1:0]       mem_addr;
    logic                               mem_ready;
    logic [MEMORY_WIDTH-1:0]            mem_data;

    modport master (
        input  req_valid, req_addr, mem_ready, mem_data,
        output req_ready, req_data, mem_valid, mem_addr
    );

    modport slave (
        output req_valid, req_addr, mem_ready, mem_data,
        input  req_ready, req_data, mem_valid, mem_addr
    );
endinterface

// File: rtl/mem_read_rr_arbiter.sv
// Round-robin arbiter sharing one memory read port among N_REQ requesters.
// A grant that the memory does not accept immediately is locked so the
// forwarded address stays stable; per-requester grant/wait statistics are
// kept alongside for the performance counters.
module mem_read_rr_arbiter #(
    parameter int N_REQ             = 2,
    parameter int REQ_ID_BITS       = 1,
    parameter int MEMORY_ADDR_WIDTH = 11,
    parameter int MEMORY_WIDTH      = 16,
    parameter int COUNT_WIDTH       = 32
) (
    input  logic                         i_clk,
    input  logic                         i_rst,        // asynchronous, active-low
    mem_read_rr_arbiter_if.master        bus,
    input  logic                         i_clr_stats,
    output logic [N_REQ*COUNT_WIDTH-1:0] o_grant_count,
    output logic [N_REQ*COUNT_WIDTH-1:0] o_wait_cycles,
    output logic [COUNT_WIDTH-1:0]       o_max_wait,
    output logic                         o_proto_err
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [REQ_ID_BITS-1:0] LAST_ID = REQ_ID_BITS'(N_REQ - 1);

    state_t                   r_state;
    state_t                   w_next_state;
    logic [REQ_ID_BITS-1:0]   r_rr_ptr;
    logic [REQ_ID_BITS-1:0]   w_next_rr_ptr;
    logic [REQ_ID_BITS-1:0]   r_grant_id;
    logic [REQ_ID_BITS-1:0]   w_next_grant_id;

    logic                     w_any;
    logic [REQ_ID_BITS-1:0]   w_winner;
    logic [N_REQ-1:0]         w_req_ready;
    logic                     w_mem_valid;
    logic [MEMORY_ADDR_WIDTH-1:0] w_mem_addr;
    logic                     w_proto_viol;
    logic [MEMORY_ADDR_WIDTH-1:0] w_addr [N_REQ];

    logic [COUNT_WIDTH-1:0]   r_grant_count [N_REQ];
    logic [COUNT_WIDTH-1:0]   r_wait_cycles [N_REQ];
    logic [COUNT_WIDTH-1:0]   r_cur_wait    [N_REQ];
    logic [COUNT_WIDTH-1:0]   r_max_wait;
    logic                     r_proto_err;
    logic                     w_accept;
    logic [COUNT_WIDTH-1:0]   w_acc_cur;

    // Requester index k places after the round-robin pointer, modulo N_REQ.
    function automatic logic [REQ_ID_BITS-1:0] f_rot_idx(
        input logic [REQ_ID_BITS-1:0] ptr,
        input int                     k
    );
        return REQ_ID_BITS'((int'(ptr) + k) % N_REQ);
    endfunction

    // Successor of a requester index; the last requester wraps to 0.
    function automatic logic [REQ_ID_BITS-1:0] f_next_id(input logic [REQ_ID_BITS-1:0] id);
        return (id == LAST_ID) ? '0 : id + 1'b1;
    endfunction

    // Saturating increment: counters stick at all-ones rather than wrapping.
    function automatic logic [COUNT_WIDTH-1:0] f_sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    for (genvar g = 0; g < N_REQ; g++) begin : g_slices
        assign w_addr[g] = bus.req_addr[g*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
        assign o_grant_count[g*COUNT_WIDTH +: COUNT_WIDTH] = r_grant_count[g];
        assign o_wait_cycles[g*COUNT_WIDTH +: COUNT_WIDTH] = r_wait_cycles[g];
    end

    assign bus.req_ready = w_req_ready;
    assign bus.req_data  = bus.mem_data;
    assign bus.mem_valid = w_mem_valid;
    assign bus.mem_addr  = w_mem_addr;
    assign o_max_wait    = r_max_wait;
    assign o_proto_err   = r_proto_err;

    // Winner search: first valid requester starting at the pointer.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise an unassigned path would infer a latch.
        w_any    = 1'b0;
        w_winner = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_any && bus.req_valid[f_rot_idx(r_rr_ptr, k)]) begin
                w_any    = 1'b1;
                w_winner = f_rot_idx(r_rr_ptr, k);
            end
        end
    end

    // Next-state and output decode of the IDLE/LOCKED arbitration FSM.
    always_comb begin
        w_next_state    = r_state;
        w_next_rr_ptr   = r_rr_ptr;
        w_next_grant_id = r_grant_id;
        w_req_ready     = '0;
        w_mem_valid     = 1'b0;
        w_mem_addr      = '0;
        w_proto_viol    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_mem_valid = 1'b1;
                    w_mem_addr  = w_addr[w_winner];
                    if (bus.mem_ready) begin
                        w_req_ready[w_winner] = 1'b1;
                        w_next_rr_ptr         = f_next_id(w_winner);
                    end else begin
                        w_next_grant_id = w_winner;
                        w_next_state    = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                // Only the locked requester is visible; others wait their turn.
                w_mem_valid = bus.req_valid[r_grant_id];
                w_mem_addr  = w_addr[r_grant_id];
                if (!bus.req_valid[r_grant_id]) begin
                    w_proto_viol = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (bus.mem_ready) begin
                    w_req_ready[r_grant_id] = 1'b1;
                    w_next_rr_ptr           = f_next_id(r_grant_id);
                    w_next_state            = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!i_rst) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
        end else begin
            r_state    <= w_next_state;
            r_rr_ptr   <= w_next_rr_ptr;
            r_grant_id <= w_next_grant_id;
        end
    end

    // Current wait of the requester being accepted this cycle (at most one).
    always_comb begin
        w_accept  = |w_req_ready;
        w_acc_cur = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_req_ready[i]) begin
                w_acc_cur = r_cur_wait[i];
            end
        end
    end

    // Per-requester grant, cumulative-wait and current-wait counters.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            // NOTE: these arrays are a handful of flops, not a RAM, so they
            // are reset element by element like any other register.
            for (int i = 0; i < N_REQ; i++) begin
                r_grant_count[i] <= '0;
                r_wait_cycles[i] <= '0;
                r_cur_wait[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (i_clr_stats) begin
                    r_grant_count[i] <= '0;
                    r_wait_cycles[i] <= '0;
                end else begin
                    if (w_req_ready[i]) begin
                        r_grant_count[i] <= f_sat_inc(r_grant_count[i]);
                    end
                    if (bus.req_valid[i] && !w_req_ready[i]) begin
                        r_wait_cycles[i] <= f_sat_inc(r_wait_cycles[i]);
                    end
                end
                // The running wait survives a statistics clear.
                if (w_req_ready[i] || !bus.req_valid[i]) begin
                    r_cur_wait[i] <= '0;
                end else begin
                    r_cur_wait[i] <= f_sat_inc(r_cur_wait[i]);
                end
            end
        end
    end

    // Longest single wait and sticky protocol-error flag.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_max_wait  <= '0;
            r_proto_err <= 1'b0;
        end else if (i_clr_stats) begin
            r_max_wait  <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_accept && (w_acc_cur > r_max_wait)) begin
                r_max_wait <= w_acc_cur;
            end
            if (w_proto_viol) begin
                r_proto_err <= 1'b1;
            end
        end
    end

endmodule
